// File: rtl/cbs_block_scheduler.sv
// Code-block scheduler: aligns the interleaver/encoder FIFO heads, streams one block to both consumers
// in lockstep, then waits for both completions. Define CBS_SCHED_TIMEOUT_EN to add the DRAIN watchdog.
module cbs_block_scheduler #(
  parameter int SMALL_BYTES = 132,
  parameter int LARGE_BYTES = 768,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  itl_q,
  input  logic        itl_empty,
  input  logic [9:0]  enc_q,
  input  logic        enc_empty,
  input  logic        itl_done,
  input  logic        enc_done,
  output logic        itl_rreq,
  output logic        enc_rreq,
  output logic [7:0]  dout_data,
  output logic        dout_size,
  output logic        dout_start,
  output logic        dout_valid,
  output logic        busy,
  output logic [15:0] blk_count,
  output logic [2:0]  err_flags
);
  typedef enum logic [1:0] {IDLE, ALIGN, STREAM, DRAIN} state_t;

  localparam logic [9:0] SMALL_LEN = 10'(SMALL_BYTES);
  localparam logic [9:0] LARGE_LEN = 10'(LARGE_BYTES);

  state_t      r_state, w_next;
  logic [9:0]  r_byte_cnt, r_len;
  logic        r_size, r_itl_dl, r_enc_dl;
  logic [7:0]  r_dout_data_p1;
  logic        r_dout_size_p1, r_dout_start_p1, r_vld_p1;
  logic [15:0] r_blk_count;
  logic [1:0]  r_err;
  logic        w_itl_rreq, w_enc_rreq, w_pop, w_last, w_go;
  logic        w_resync, w_mismatch, w_blk_done;
  logic        w_unused_itl_data;
`ifdef CBS_SCHED_TIMEOUT_EN
  logic [12:0] r_wdog;
  logic        r_err_to, w_timeout;
`endif

  // Interleaver payload is identical to the encoder copy and is never forwarded.
  assign w_unused_itl_data = ^itl_q[9:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_itl_rreq = 1'b0;
    w_enc_rreq = 1'b0;
    w_pop      = 1'b0;
    w_last     = 1'b0;
    w_go       = 1'b0;
    w_resync   = 1'b0;
    w_mismatch = 1'b0;
    w_blk_done = 1'b0;
`ifdef CBS_SCHED_TIMEOUT_EN
    w_timeout  = 1'b0;
`endif
    case (r_state)
      IDLE: w_next = ALIGN;
      ALIGN: begin
        if (enable) begin
          if (!itl_empty && !itl_q[0]) begin
            w_itl_rreq = 1'b1;
            w_resync   = 1'b1;
          end
          if (!enc_empty && !enc_q[0]) begin
            w_enc_rreq = 1'b1;
            w_resync   = 1'b1;
          end
          if (!itl_empty && !enc_empty && itl_q[0] && enc_q[0]) begin
            if (itl_q[1] == enc_q[1]) begin
              w_go   = 1'b1;
              w_next = STREAM;
            end else begin
              w_itl_rreq = 1'b1;
              w_enc_rreq = 1'b1;
              w_mismatch = 1'b1;
            end
          end
        end
      end
      STREAM: begin
        // Both FIFOs are popped together or not at all so the consumers never drift apart.
        w_pop      = !itl_empty && !enc_empty;
        w_itl_rreq = w_pop;
        w_enc_rreq = w_pop;
        w_last     = w_pop && (r_byte_cnt == r_len - 10'd1);
        if (w_pop && (r_byte_cnt != 10'd0) && (itl_q[0] || enc_q[0])) w_resync = 1'b1;
        if (w_last) w_next = DRAIN;
      end
      DRAIN: begin
        if ((r_itl_dl || itl_done) && (r_enc_dl || enc_done)) begin
          w_blk_done = 1'b1;
          w_next     = ALIGN;
        end
`ifdef CBS_SCHED_TIMEOUT_EN
        else if (r_wdog == 13'(TIMEOUT_CYC - 1)) begin
          w_timeout = 1'b1;
          w_next    = ALIGN;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  // Stage p1: FIFO head to registered output, one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt      <= '0;
      r_len           <= '0;
      r_size          <= 1'b0;
      r_itl_dl        <= 1'b0;
      r_enc_dl        <= 1'b0;
      r_dout_data_p1  <= '0;
      r_dout_size_p1  <= 1'b0;
      r_dout_start_p1 <= 1'b0;
      r_vld_p1        <= 1'b0;
      r_blk_count     <= '0;
      r_err           <= '0;
    end else begin
      r_vld_p1 <= w_pop;
      if (w_pop) begin
        r_dout_data_p1  <= enc_q[9:2];
        r_dout_size_p1  <= r_size;
        r_dout_start_p1 <= (r_byte_cnt == 10'd0);
        r_byte_cnt      <= w_last ? 10'd0 : r_byte_cnt + 10'd1;
      end
      if (w_go) begin
        r_size     <= enc_q[1];
        r_len      <= enc_q[1] ? LARGE_LEN : SMALL_LEN;
        r_byte_cnt <= 10'd0;
        r_itl_dl   <= 1'b0;
        r_enc_dl   <= 1'b0;
      end else if (r_state == STREAM || r_state == DRAIN) begin
        if (itl_done) r_itl_dl <= 1'b1;
        if (enc_done) r_enc_dl <= 1'b1;
      end
      if (w_blk_done) r_blk_count <= r_blk_count + 16'd1;
      r_err <= r_err | {w_mismatch, w_resync};
    end
  end

`ifdef CBS_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog   <= '0;
      r_err_to <= 1'b0;
    end else begin
      r_wdog   <= (r_state == DRAIN) ? r_wdog + 13'd1 : 13'd0;
      r_err_to <= r_err_to | w_timeout;
    end
  end
  assign err_flags = {r_err_to, r_err};
`else
  assign err_flags = {1'b0, r_err};
`endif

  assign itl_rreq   = w_itl_rreq;
  assign enc_rreq   = w_enc_rreq;
  assign dout_data  = r_dout_data_p1;
  assign dout_size  = r_dout_size_p1;
  assign dout_start = r_dout_start_p1;
  assign dout_valid = r_vld_p1;
  assign busy       = (r_state == STREAM) || (r_state == DRAIN);
  assign blk_count  = r_blk_count;
endmodule
